// File: rtl/alu_ctrl_stage.sv
// ID/EX ALU-control stage: decodes the IF/ID instruction into ALU op and operand
// selects, registered with stall/flush/valid handling and an illegal-op counter.
module alu_ctrl_stage (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        InValid,
  input  logic        Stall,
  input  logic        Flush,
  output logic [3:0]  ALUCtrlOut,
  output logic        UseShamt,
  output logic [4:0]  ShamtOut,
  output logic        UseImm,
  output logic [31:0] ImmOut,
  output logic        OutValid,
  output logic        IllegalOp,
  output logic [7:0]  IllegalCount
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_ADDU = 4'b1000,
    ALU_SUBU = 4'b1001,
    ALU_XOR  = 4'b1010,
    ALU_SLTU = 4'b1011,
    ALU_NOR  = 4'b1100,
    ALU_SRA  = 4'b1101,
    ALU_LUI  = 4'b1110
  } alu_op_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ADDIU = 6'h09,
    OP_SLTI  = 6'h0A,
    OP_SLTIU = 6'h0B,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_XORI  = 6'h0E,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_SRL  = 6'h02,
    FN_SRA  = 6'h03,
    FN_SLLV = 6'h04,
    FN_SRLV = 6'h06,
    FN_SRAV = 6'h07,
    FN_ADD  = 6'h20,
    FN_ADDU = 6'h21,
    FN_SUB  = 6'h22,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25,
    FN_XOR  = 6'h26,
    FN_NOR  = 6'h27,
    FN_SLT  = 6'h2A,
    FN_SLTU = 6'h2B
  } funct_e;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_reg_fields;

  assign opcode = Instr[31:26];
  assign funct  = Instr[5:0];
  assign shamt  = Instr[10:6];
  assign imm    = Instr[15:0];
  assign unused_reg_fields = ^Instr[25:16];

  alu_op_e     dec_alu;
  logic        dec_use_shamt;
  logic        dec_use_imm;
  logic        dec_zext;
  logic        dec_illegal;
  logic [31:0] dec_imm;

  always_comb begin
    dec_alu       = ALU_AND;
    dec_use_shamt = 1'b0;
    dec_use_imm   = 1'b0;
    dec_zext      = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_ADDU: dec_alu = ALU_ADDU;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_SUBU: dec_alu = ALU_SUBU;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_XOR:  dec_alu = ALU_XOR;
          FN_NOR:  dec_alu = ALU_NOR;
          FN_SLT:  dec_alu = ALU_SLT;
          FN_SLTU: dec_alu = ALU_SLTU;
          FN_SLL: begin
            dec_alu       = ALU_SLL;
            dec_use_shamt = 1'b1;
          end
          FN_SRL: begin
            dec_alu       = ALU_SRL;
            dec_use_shamt = 1'b1;
          end
          FN_SRA: begin
            dec_alu       = ALU_SRA;
            dec_use_shamt = 1'b1;
          end
          FN_SLLV: dec_alu = ALU_SLL;
          FN_SRLV: dec_alu = ALU_SRL;
          FN_SRAV: dec_alu = ALU_SRA;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_alu     = ALU_ADD;
        dec_use_imm = 1'b1;
      end
      OP_ADDIU: begin
        dec_alu     = ALU_ADDU;
        dec_use_imm = 1'b1;
      end
      OP_SLTI: begin
        dec_alu     = ALU_SLT;
        dec_use_imm = 1'b1;
      end
      OP_SLTIU: begin
        dec_alu     = ALU_SLTU;
        dec_use_imm = 1'b1;
      end
      OP_ANDI: begin
        dec_alu     = ALU_AND;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b1;
      end
      OP_ORI: begin
        dec_alu     = ALU_OR;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b1;
      end
      OP_XORI: begin
        dec_alu     = ALU_XOR;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b1;
      end
      OP_LUI: begin
        dec_alu     = ALU_LUI;
        dec_use_imm = 1'b1;
        dec_zext    = 1'b1;
      end
      OP_BEQ, OP_BNE: dec_alu = ALU_SUB;
      OP_J, OP_JAL:   dec_alu = ALU_AND;
      default:        dec_illegal = 1'b1;
    endcase
  end

  // Illegal encodings force a zero immediate so EX sees deterministic operands.
  always_comb begin
    if (dec_illegal)
      dec_imm = '0;
    else if (dec_zext)
      dec_imm = {16'h0000, imm};
    else
      dec_imm = {{16{imm[15]}}, imm};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ALUCtrlOut   <= '0;
      UseShamt     <= 1'b0;
      ShamtOut     <= '0;
      UseImm       <= 1'b0;
      ImmOut       <= '0;
      OutValid     <= 1'b0;
      IllegalOp    <= 1'b0;
      IllegalCount <= '0;
    end else if (Flush || (!Stall && !InValid)) begin
      ALUCtrlOut <= '0;
      UseShamt   <= 1'b0;
      ShamtOut   <= '0;
      UseImm     <= 1'b0;
      ImmOut     <= '0;
      OutValid   <= 1'b0;
      IllegalOp  <= 1'b0;
    end else if (!Stall) begin
      ALUCtrlOut <= dec_alu;
      UseShamt   <= dec_use_shamt;
      ShamtOut   <= shamt;
      UseImm     <= dec_use_imm;
      ImmOut     <= dec_imm;
      OutValid   <= 1'b1;
      IllegalOp  <= dec_illegal;
      if (dec_illegal && (IllegalCount != '1))
        IllegalCount <= IllegalCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Self-checking bench for alu_ctrl_stage: directed vector table, saturation
// sequence, then randomized traffic against a table-lookup reference model.
module tb_alu_ctrl_stage;

  logic        CLK = 1'b0;
  logic        Reset, InValid, Stall, Flush;
  logic [31:0] Instr;
  logic [3:0]  ALUCtrlOut;
  logic        UseShamt, UseImm, OutValid, IllegalOp;
  logic [4:0]  ShamtOut;
  logic [31:0] ImmOut;
  logic [7:0]  IllegalCount;

  alu_ctrl_stage dut (
    .CLK(CLK), .Reset(Reset), .Instr(Instr), .InValid(InValid),
    .Stall(Stall), .Flush(Flush), .ALUCtrlOut(ALUCtrlOut),
    .UseShamt(UseShamt), .ShamtOut(ShamtOut), .UseImm(UseImm),
    .ImmOut(ImmOut), .OutValid(OutValid), .IllegalOp(IllegalOp),
    .IllegalCount(IllegalCount)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  alu;
    logic        ush;
    logic [4:0]  sh;
    logic        uimm;
    logic [31:0] imm;
    logic        ov;
    logic        ill;
    logic [7:0]  cnt;
  } out_t;

  typedef struct {
    string       name;
    bit          rst, stall, flush, inval;
    logic [31:0] instr;
    out_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  // Reference tables: code for each legal R funct / opcode.
  int r_alu[int];
  bit r_shamt[int];
  int i_alu[int];
  int i_kind[int];  // 0: no imm (sext), 1: sext imm, 2: zext imm

  out_t m_out;
  int   m_cnt;

  function automatic vec_t mk(string n, bit rst, bit st, bit fl, bit iv, logic [31:0] ins,
                              logic [3:0] alu, logic ush, logic [4:0] sh, logic uimm,
                              logic [31:0] imm, logic ov, logic ill, logic [7:0] cnt);
    vec_t v;
    v.name = n; v.rst = rst; v.stall = st; v.flush = fl; v.inval = iv; v.instr = ins;
    v.exp = '{alu: alu, ush: ush, sh: sh, uimm: uimm, imm: imm, ov: ov, ill: ill, cnt: cnt};
    return v;
  endfunction

  function automatic out_t ref_decode(logic [31:0] ins);
    out_t o = '0;
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
    o.ov = 1'b1;
    o.sh = ins[10:6];
    if (op == 0 && r_alu.exists(fn)) begin
      o.alu = 4'(r_alu[fn]);
      o.ush = r_shamt.exists(fn);
      o.imm = sx;
    end else if (op != 0 && i_alu.exists(op)) begin
      o.alu  = 4'(i_alu[op]);
      o.uimm = (i_kind[op] != 0);
      o.imm  = (i_kind[op] == 2) ? {16'h0, ins[15:0]} : sx;
    end else begin
      o.ill = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t actual();
    return '{alu: ALUCtrlOut, ush: UseShamt, sh: ShamtOut, uimm: UseImm, imm: ImmOut,
             ov: OutValid, ill: IllegalOp, cnt: IllegalCount};
  endfunction

  task automatic step(input string n, input bit rst, input bit st, input bit fl,
                      input bit iv, input logic [31:0] ins, input out_t exp);
    out_t act;
    Reset = rst; Stall = st; Flush = fl; InValid = iv; Instr = ins;
    @(posedge CLK);
    #1;
    act = actual();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Abstract model: what the register should hold after one edge with these inputs.
  task automatic model_edge(input bit rst, input bit st, input bit fl, input bit iv,
                            input logic [31:0] ins);
    out_t d;
    if (rst) begin
      m_out = '0; m_cnt = 0;
    end else if (fl) begin
      m_out = '0;
    end else if (!st) begin
      if (iv) begin
        d = ref_decode(ins);
        if (d.ill) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        m_out = d;
      end else begin
        m_out = '0;
      end
    end
    m_out.cnt = 8'(m_cnt);
  endtask

  initial begin
    out_t e;
    int   op_pool[$];
    int   fn_pool[$];

    r_alu[32'h20] = 2;  r_alu[32'h21] = 8;  r_alu[32'h22] = 6;  r_alu[32'h23] = 9;
    r_alu[32'h24] = 0;  r_alu[32'h25] = 1;  r_alu[32'h26] = 10; r_alu[32'h27] = 12;
    r_alu[32'h2A] = 7;  r_alu[32'h2B] = 11;
    r_alu[32'h00] = 3;  r_alu[32'h02] = 4;  r_alu[32'h03] = 13;
    r_alu[32'h04] = 3;  r_alu[32'h06] = 4;  r_alu[32'h07] = 13;
    r_shamt[32'h00] = 1; r_shamt[32'h02] = 1; r_shamt[32'h03] = 1;
    i_alu[32'h08] = 2;  i_kind[32'h08] = 1;  i_alu[32'h09] = 8;  i_kind[32'h09] = 1;
    i_alu[32'h0A] = 7;  i_kind[32'h0A] = 1;  i_alu[32'h0B] = 11; i_kind[32'h0B] = 1;
    i_alu[32'h23] = 2;  i_kind[32'h23] = 1;  i_alu[32'h2B] = 2;  i_kind[32'h2B] = 1;
    i_alu[32'h0C] = 0;  i_kind[32'h0C] = 2;  i_alu[32'h0D] = 1;  i_kind[32'h0D] = 2;
    i_alu[32'h0E] = 10; i_kind[32'h0E] = 2;  i_alu[32'h0F] = 14; i_kind[32'h0F] = 2;
    i_alu[32'h04] = 6;  i_kind[32'h04] = 0;  i_alu[32'h05] = 6;  i_kind[32'h05] = 0;
    i_alu[32'h02] = 0;  i_kind[32'h02] = 0;  i_alu[32'h03] = 0;  i_kind[32'h03] = 0;

    //                 name        rst st fl iv instr          alu  us sh  ui imm           ov il cnt
    tbl.push_back(mk("reset",      1, 0, 0, 0, 32'h00000000, 4'h0, 0, 0,  0, 32'h00000000, 0, 0, 0));
    tbl.push_back(mk("add",        0, 0, 0, 1, 32'h02328020, 4'h2, 0, 0,  0, 32'hFFFF8020, 1, 0, 0));
    tbl.push_back(mk("addi",       0, 0, 0, 1, 32'h2208FFFF, 4'h2, 0, 31, 1, 32'hFFFFFFFF, 1, 0, 0));
    tbl.push_back(mk("andi",       0, 0, 0, 1, 32'h3108FFFF, 4'h0, 0, 31, 1, 32'h0000FFFF, 1, 0, 0));
    tbl.push_back(mk("lui",        0, 0, 0, 1, 32'h3C01ABCD, 4'hE, 0, 15, 1, 32'h0000ABCD, 1, 0, 0));
    tbl.push_back(mk("sra",        0, 0, 0, 1, 32'h00084083, 4'hD, 1, 2,  0, 32'h00004083, 1, 0, 0));
    tbl.push_back(mk("srav",       0, 0, 0, 1, 32'h01094007, 4'hD, 0, 0,  0, 32'h00004007, 1, 0, 0));
    tbl.push_back(mk("add2",       0, 0, 0, 1, 32'h02328020, 4'h2, 0, 0,  0, 32'hFFFF8020, 1, 0, 0));
    tbl.push_back(mk("stall1",     0, 1, 0, 1, 32'h3C01ABCD, 4'h2, 0, 0,  0, 32'hFFFF8020, 1, 0, 0));
    tbl.push_back(mk("stall2",     0, 1, 0, 1, 32'hFC000000, 4'h2, 0, 0,  0, 32'hFFFF8020, 1, 0, 0));
    tbl.push_back(mk("stall3",     0, 1, 0, 0, 32'h2208FFFF, 4'h2, 0, 0,  0, 32'hFFFF8020, 1, 0, 0));
    tbl.push_back(mk("stallflush", 0, 1, 1, 1, 32'h2208FFFF, 4'h0, 0, 0,  0, 32'h00000000, 0, 0, 0));
    tbl.push_back(mk("unstall",    0, 0, 0, 1, 32'h3108FFFF, 4'h0, 0, 31, 1, 32'h0000FFFF, 1, 0, 0));
    tbl.push_back(mk("illegal",    0, 0, 0, 1, 32'hFC000000, 4'h0, 0, 0,  0, 32'h00000000, 1, 1, 1));
    tbl.push_back(mk("ill_noval",  0, 0, 0, 0, 32'hFC000000, 4'h0, 0, 0,  0, 32'h00000000, 0, 0, 1));
    tbl.push_back(mk("ill_funct",  0, 0, 0, 1, 32'h000011C1, 4'h0, 0, 7,  0, 32'h00000000, 1, 1, 2));
    tbl.push_back(mk("ill_flush",  0, 0, 1, 1, 32'hFC000000, 4'h0, 0, 0,  0, 32'h00000000, 0, 0, 2));
    tbl.push_back(mk("nop",        0, 0, 0, 1, 32'h00000000, 4'h3, 1, 0,  0, 32'h00000000, 1, 0, 2));
    tbl.push_back(mk("beq",        0, 0, 0, 1, 32'h1109FFFE, 4'h6, 0, 31, 0, 32'hFFFFFFFE, 1, 0, 2));
    tbl.push_back(mk("jal",        0, 0, 0, 1, 32'h0C000010, 4'h0, 0, 0,  0, 32'h00000010, 1, 0, 2));
    tbl.push_back(mk("rst_stall",  1, 1, 0, 1, 32'h02328020, 4'h0, 0, 0,  0, 32'h00000000, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].inval, tbl[i].instr, tbl[i].exp);

    // Saturation: 300 illegal loads, count climbs to 255 and sticks.
    for (int i = 0; i < 300; i++) begin
      e = '0; e.ov = 1; e.ill = 1; e.cnt = 8'((i + 1 > 255) ? 255 : i + 1);
      step("saturate", 0, 0, 0, 1, 32'hFC000000, e);
    end
    e = '0; e.cnt = 8'd255;
    step("sat_noval", 0, 0, 0, 0, 32'hFC000000, e);
    e = '0;
    step("sat_reset", 1, 0, 1, 1, 32'hFC000000, e);

    // Randomized traffic against the reference model.
    op_pool = '{0, 0, 0, 0, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
    fn_pool = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
    m_out = '0; m_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      bit rst, st, fl, iv;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0)
        ins[31:26] = 6'(op_pool[$urandom_range(0, op_pool.size() - 1)]);
      if ($urandom_range(0, 7) != 0)
        ins[5:0] = 6'(fn_pool[$urandom_range(0, fn_pool.size() - 1)]);
      rst = (i == 0) || ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 5) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      iv  = ($urandom_range(0, 7) != 0);
      model_edge(rst, st, fl, iv, ins);
      step("random", rst, st, fl, iv, ins, m_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered ALU-control stage sitting at the ID/EX boundary of the pipelined MIPS core. It decodes the instruction held in IF/ID into the 4-bit ALU operation code and operand-select controls, then holds them in a pipeline register that feeds the ALU's `ALUCtrl` and operand muxes in EX. The pipeline register supports stall (hold), flush (bubble insert) and valid tracking. A saturating counter of illegal instructions is provided for debug.

## Interface
- No parameters.
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Instr  input  32  instruction from IF/ID; opcode [31:26], shamt [10:6], funct [5:0], imm [15:0].
- InValid  input  1  Instr is a real instruction (0 = bubble).
- Stall  input  1  hold the pipeline register.
- Flush  input  1  replace the next register contents with a bubble.
- ALUCtrlOut  output  4  ALU operation code for EX.
- UseShamt  output  1  drive the ALU's BusA from ShamtOut (SLL/SRL/SRA).
- ShamtOut  output  5  Instr[10:6], registered.
- UseImm  output  1  drive the ALU's BusB from ImmOut.
- ImmOut  output  32  extended immediate.
- OutValid  output  1  register holds a valid instruction.
- IllegalOp  output  1  registered instruction is undecodable.
- IllegalCount  output  8  saturating count of illegal instructions loaded.

## Operation
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100
  - SUB 0110, SLT 0111, ADDU 1000, SUBU 1001, XOR 1010
  - SLTU 1011, NOR 1100, SRA 1101, LUI 1110
- R-type decode (opcode 0x00), by funct:
  - 0x20 ADD, 0x21 ADDU, 0x22 SUB, 0x23 SUBU
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR
  - 0x2A SLT, 0x2B SLTU
  - 0x00 SLL, 0x02 SRL, 0x03 SRA, each with UseShamt=1
  - 0x04 SLLV → SLL, 0x06 SRLV → SRL, 0x07 SRAV → SRA, each with UseShamt=0
  - All R-type: UseImm=0.
- I-type decode, UseImm=1:
  - Sign-extend ImmOut: addi 0x08 ADD, addiu 0x09 ADDU, slti 0x0A SLT, sltiu 0x0B SLTU, lw 0x23 ADD, sw 0x2B ADD.
  - Zero-extend ImmOut: andi 0x0C AND, ori 0x0D OR, xori 0x0E XOR, lui 0x0F LUI.
- Branch and jump decode:
  - beq 0x04, bne 0x05 → SUB, UseImm=0; Zero flag compares registers.
  - j 0x02, jal 0x03 → AND, UseImm=0, not illegal.
- Any other opcode or R-type funct:
  - IllegalOp=1, ALUCtrlOut=AND, UseShamt=0, UseImm=0, ImmOut=0.
- ImmOut for R-type and branches is the sign-extended imm field (don't-care to EX, but deterministic).
- Bubble contents:
  - OutValid=0, ALUCtrlOut=0000, UseShamt=0, UseImm=0, ShamtOut=0, ImmOut=0, IllegalOp=0.
- Register update priority each rising edge:
  1. Reset: all outputs 0, including IllegalCount.
  2. Flush: load bubble (Flush wins over Stall).
  3. Stall: hold every output.
  4. Otherwise: load decode of Instr if InValid=1, else load bubble.
- IllegalCount:
  - Increments by 1 on an edge that loads IllegalOp=1 with InValid=1 (priority 4 only).
  - Saturates at 255; never wraps.
  - Not changed by stall, flush or bubble loads.

## Timing
- Latency is 1 cycle: Instr sampled at edge N appears on outputs after edge N.
- Outputs are purely registered; no combinational path from any input to any output.
- Reset value of every output is 0.
- Stall held for K cycles keeps outputs constant for K cycles. The instruction presented on the first unstalled edge is loaded on that edge.
- Reset asserted during Stall or Flush still clears everything on the next edge.
- Instr=0x00000000 with InValid=1 is a valid SLL (NOP), not illegal.

## Test plan
- Reset, then Instr=0x02328020 (add) with InValid=1 → after one edge: ALUCtrlOut=0010, UseImm=0, UseShamt=0, OutValid=1, IllegalOp=0.
- Instr=0x2208FFFF (addi) → ALUCtrlOut=0010, UseImm=1, ImmOut=0xFFFFFFFF. Then 0x3108FFFF (andi) → ALUCtrlOut=0000, ImmOut=0x0000FFFF. Then 0x3C01ABCD (lui) → ALUCtrlOut=1110, ImmOut=0x0000ABCD.
- Instr=0x00084083 (sra shamt 2) → ALUCtrlOut=1101, UseShamt=1, ShamtOut=00010. Then 0x01094007 (srav) → ALUCtrlOut=1101, UseShamt=0.
- Load add, then Stall=1 for 3 cycles while Instr changes → outputs stay at add. Then Stall=1 and Flush=1 together → bubble: OutValid=0, ALUCtrlOut=0000.
- Instr=0xFC000000 (opcode 0x3F) → IllegalOp=1, IllegalCount=1. 300 consecutive illegal loads → IllegalCount=255 and holds. Illegal Instr with InValid=0 → count unchanged.
- Reset asserted mid-stream with Stall=1 → all outputs 0 after the next edge.
